wide_add_seq: RTL and testbench



---
 rtl/wide_add_seq.sv | 105 ++++++++++
 tb/tb_wide_add_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer driving one shared N-bit adder, low chunk first.
// Latency: CHUNKS cycles from the start edge to done; issue interval is CHUNKS+2 cycles.
// Backpressure: start is taken only in IDLE. It is ignored in RUN and DONE, and nothing is queued.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   start, sub, a_in, b_in  request handshake; operands and mode are sampled with start
//   busy, done              busy while RUN; done is a single-cycle pulse with the final result
//   result, carry_out, ovf  W-bit result, final carry (no-borrow for subtract), signed overflow
//   add_a, add_b, add_cin   operand and carry-in to the shared adder (zero outside RUN)
//   add_sum, add_carry      combinational sum and carry back from the shared adder
module wide_add_seq #(
    parameter int N      = 32,
    parameter int CHUNKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [N*CHUNKS-1:0] a_in,
    input  logic [N*CHUNKS-1:0] b_in,
    output logic                busy,
    output logic                done,
    output logic [N*CHUNKS-1:0] result,
    output logic                carry_out,
    output logic                ovf,
    output logic [N-1:0]        add_a,
    output logic [N-1:0]        add_b,
    output logic                add_cin,
    input  logic [N-1:0]        add_sum,
    input  logic                add_carry
);

    localparam int W  = N * CHUNKS;
    localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;   // already inverted for subtract, so the adder always adds
    logic          cy_q;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // The shared adder sees zeros whenever this block is not actively using it.
    assign add_a   = busy ? a_q[idx*N +: N] : '0;
    assign add_b   = busy ? b_q[idx*N +: N] : '0;
    assign add_cin = busy ? cy_q : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cy_q      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q       <= a_in;
                        b_q       <= sub ? ~b_in : b_in;
                        // A - B is computed as A + ~B + 1; the +1 enters as the first carry-in.
                        cy_q      <= sub;
                        idx       <= '0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        ovf       <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    result[idx*N +: N] <= add_sum;
                    cy_q               <= add_carry;
                    idx                <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        carry_out <= add_carry;
                        // Overflow happens when both effective operands share a sign
                        // and the top chunk's sum bit disagrees with it.
                        ovf       <= (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
                        idx       <= '0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq. The shared adder is modelled here, and results are checked against plain wide arithmetic.
// Latency: every operation is expected to raise done CHUNKS cycles after its start edge.
// Backpressure: covers starts ignored while busy and back-to-back issue with start held high.
module tb_wide_add_seq;

    localparam int N      = 32;
    localparam int CHUNKS = 4;
    localparam int W      = N * CHUNKS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          ovf;
    logic [N-1:0]  add_a;
    logic [N-1:0]  add_b;
    logic          add_cin;
    logic [N-1:0]  add_sum;
    logic          add_carry;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // The attached ripple-carry adder is purely combinational.
    assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    wide_add_seq #(.N(N), .CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .ovf       (ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_carry (add_carry)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: modulo-2^W arithmetic, unsigned compare for borrow, and a W+1-bit signed sum for overflow.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0]        u;
        logic signed [W:0] sa, sb, sr;
        u  = {1'b0, a} + {1'b0, b};
        sa = {a[W-1], a};
        sb = {b[W-1], b};
        sr = s ? (sa - sb) : (sa + sb);
        r  = s ? (a - b) : (a + b);
        c  = s ? (a >= b) : u[W];
        v  = (sr[W] != sr[W-1]);
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] x;
        for (int i = 0; i < CHUNKS; i++) x[i*N +: N] = $urandom;
        return x;
    endfunction

    // One operation: samples every negedge after the start edge (index 0 = first cycle of RUN).
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] er, r_at;
        logic         ec, ev, c_at, v_at;
        int           busy_cnt, done_cnt, done_at;
        model(a, b, s, er, ec, ev);
        @(negedge clk);
        a_in = a; b_in = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = rnd_w(); b_in = rnd_w(); sub = ~s;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        r_at = '0; c_at = 1'b0; v_at = 1'b0;
        for (int i = 0; i < CHUNKS + 3; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    r_at = result; c_at = carry_out; v_at = ovf;
                end
            end
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, W'(busy_cnt), W'(CHUNKS));
        chk({tag, ".done_at"}, W'(done_at), W'(CHUNKS));
        chk({tag, ".done_pulses"}, W'(done_cnt), W'(1));
        chk({tag, ".result"}, r_at, er);
        chk({tag, ".carry_out"}, W'(c_at), W'(ec));
        chk({tag, ".ovf"}, W'(v_at), W'(ev));
        chk({tag, ".result_held"}, result, er);
    endtask

    initial begin
        logic [W-1:0] er, er2, r_at;
        logic         ec, ev;
        int           done_cnt, d1, d2;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
        #1;
        chk("reset.flags", W'({busy, done, carry_out, ovf, add_cin}), W'(0));
        chk("reset.result", result, '0);
        chk("reset.adder", W'({add_a, add_b}), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the plan.
        run_op("ripple", {{(W-N){1'b0}}, {N{1'b1}}}, W'(1), 1'b0);
        run_op("wrap", {W{1'b1}}, W'(1), 1'b0);
        run_op("borrow", W'(5), W'(7), 1'b1);
        run_op("noborrow", W'(7), W'(5), 1'b1);
        run_op("sovf", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);
        run_op("sub_sovf", {1'b1, {(W-1){1'b0}}}, W'(1), 1'b1);

        // Start while busy is ignored: first result stands, single done.
        model(W'(100), W'(23), 1'b0, er, ec, ev);
        @(negedge clk);
        a_in = W'(100); b_in = W'(23); sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0; r_at = '0;
        for (int i = 0; i < 2 * CHUNKS + 4; i++) begin
            if (i == 2) begin start = 1'b1; a_in = rnd_w(); b_in = rnd_w(); sub = 1'b1; end
            if (i == 3) start = 1'b0;
            if (done) begin done_cnt++; r_at = result; end
            @(negedge clk);
        end
        chk("ignore.done_pulses", W'(done_cnt), W'(1));
        chk("ignore.result", r_at, er);

        // Start held high: back-to-back ops, one every CHUNKS+2 cycles.
        model(W'(9), W'(4), 1'b1, er2, ec, ev);
        @(negedge clk);
        a_in = W'(9); b_in = W'(4); sub = 1'b1; start = 1'b1;
        @(negedge clk);
        done_cnt = 0; d1 = -1; d2 = -1; r_at = '0;
        for (int i = 0; i < 2 * CHUNKS + 6; i++) begin
            if (done) begin
                done_cnt++;
                if (d1 < 0) d1 = i; else if (d2 < 0) begin d2 = i; r_at = result; end
            end
            if (i == 2 * CHUNKS + 2) start = 1'b0;
            @(negedge clk);
        end
        chk("held.first_done", W'(d1), W'(CHUNKS));
        chk("held.second_done", W'(d2), W'(2 * CHUNKS + 2));
        chk("held.done_pulses", W'(done_cnt), W'(2));
        chk("held.result", r_at, er2);

        // Reset in the middle of RUN, with idx at 2 and partial chunks already written.
        @(negedge clk);
        a_in = {CHUNKS{32'h1111_1111}}; b_in = {CHUNKS{32'h2222_2222}}; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst.partial_written", W'(result[N-1:0] != '0), W'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.flags", W'({busy, done, carry_out, ovf, add_cin}), W'(0));
        chk("midrst.result", result, '0);
        chk("midrst.adder", W'({add_a, add_b}), W'(0));
        done_cnt = 0;
        for (int i = 0; i < CHUNKS + 2; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (i == 1) rst_n = 1'b1;
        end
        chk("midrst.no_done", W'(done_cnt), W'(0));
        run_op("after_rst", W'(3), W'(4), 1'b0);

        // Randomized operations.
        for (int n = 0; n < 16; n++) begin
            run_op($sformatf("rand%0d", n), rnd_w(), rnd_w(), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bounds the run regardless of DUT behaviour.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
